// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between the instruction-fetch port
//            and the load/store port. One winner per transaction, fixed
//            memory latency, data priority with a starvation guard for fetch.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            if_req/if_addr      - fetch request (held until if_gnt)
//            if_gnt/if_rvalid/if_rdata - fetch grant pulse, response pulse, data
//            d_req/d_addr/d_wdata/d_we - load/store request (d_we = 0 is a load)
//            d_gnt/d_rvalid/d_rdata    - data grant pulse, response pulse, data
//            mem_en/mem_addr/mem_wdata/mem_we/mem_rdata - memory port
//            busy                - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,   // legal 1..15
    parameter int STARVE_MAX = 4    // legal 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_we,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q;
    logic [3:0]        starve_cnt_q;
    logic [3:0]        lat_cnt_q;
    logic              owner_d_q;      // 1: data port owns the transaction
    logic              if_gnt_q;
    logic              if_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_gnt_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_we_q;
    logic              busy_q;

    logic              arb_take_d;
    logic              data_wins_d;
    logic [3:0]        starve_cnt_d;

    // Arbitration decision, only acted upon in IDLE and RESP.
    always_comb begin
        arb_take_d   = ((state_q == S_IDLE) || (state_q == S_RESP)) && (if_req || d_req);
        // Data wins unless fetch has been passed over STARVE_MAX times in a row.
        data_wins_d  = d_req && !(if_req && (starve_cnt_q == STARVE_LIM));
        starve_cnt_d = 4'd0;
        if (data_wins_d && if_req) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= 4'd0;
            lat_cnt_q    <= 4'd0;
            owner_d_q    <= 1'b0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            d_gnt_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 4'd0;
            busy_q       <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;

            case (state_q)
                S_IDLE, S_RESP: begin
                    if (arb_take_d) begin
                        state_q      <= S_ISSUE;
                        owner_d_q    <= data_wins_d;
                        starve_cnt_q <= starve_cnt_d;
                        mem_addr_q   <= data_wins_d ? d_addr  : if_addr;
                        mem_wdata_q  <= data_wins_d ? d_wdata : '0;
                        mem_we_q     <= data_wins_d ? d_we    : 4'd0;
                        // Strobe and grant are registered here so they appear
                        // together during the ISSUE cycle.
                        mem_en_q     <= 1'b1;
                        if_gnt_q     <= !data_wins_d;
                        d_gnt_q      <= data_wins_d;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    state_q   <= S_WAIT;
                    lat_cnt_q <= LAT_LOAD;
                end

                S_WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        if (owner_d_q) begin
                            // Stores return zero so the LSU sees a clean ack.
                            d_rdata_q  <= (mem_we_q == 4'd0) ? mem_rdata : '0;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire
